// File: rtl/controle_envase_if.sv
// Signal bundle between the bottling-station sequencer and the line/sealer.
// The sequencer takes the master view; the plant side (sensors, sealer, operator) takes the slave view.
interface controle_envase_if #(
  parameter int unsigned ROLHAS_MAX = 20,
  parameter int unsigned LOTE       = 12
);
  localparam int unsigned RW = $clog2(ROLHAS_MAX + 1);
  localparam int unsigned GW = $clog2(LOTE);

  logic          START;
  logic          ALARME_ACK;
  logic          SENSOR_GARRAFA;
  logic          SENSOR_NIVEL;
  logic          GARRAFA_VEDADA;
  logic          DECREMENTA_ROLHA;
  logic          ABASTECE_ROLHAS;
  logic          MOTOR;
  logic          VALVULA;
  logic          GARRAFA_PRESENTE;
  logic          ROLHAS_DISPONIVEIS;
  logic [RW-1:0] ROLHAS_CONT;
  logic [GW-1:0] GARRAFAS_CONT;
  logic          LOTE_COMPLETO;
  logic          ALARME;
  logic [1:0]    ALARME_COD;

  modport master (
    input  START, ALARME_ACK, SENSOR_GARRAFA, SENSOR_NIVEL, GARRAFA_VEDADA,
           DECREMENTA_ROLHA, ABASTECE_ROLHAS,
    output MOTOR, VALVULA, GARRAFA_PRESENTE, ROLHAS_DISPONIVEIS, ROLHAS_CONT,
           GARRAFAS_CONT, LOTE_COMPLETO, ALARME, ALARME_COD
  );

  modport slave (
    output START, ALARME_ACK, SENSOR_GARRAFA, SENSOR_NIVEL, GARRAFA_VEDADA,
           DECREMENTA_ROLHA, ABASTECE_ROLHAS,
    input  MOTOR, VALVULA, GARRAFA_PRESENTE, ROLHAS_DISPONIVEIS, ROLHAS_CONT,
           GARRAFAS_CONT, LOTE_COMPLETO, ALARME, ALARME_COD
  );
endinterface

// File: rtl/controle_envase.sv
// Filling/sealing station sequencer: conveyor, fill valve, sealer handoff,
// cork stock counter, batch counter and latched alarm with cause code.
module controle_envase #(
  parameter int unsigned ROLHAS_MAX  = 20,
  parameter int unsigned REFILL_QTD  = 15,
  parameter int unsigned T_ENCHE_MAX = 1000,
  parameter int unsigned T_VEDA_MAX  = 200,
  parameter int unsigned LOTE        = 12
) (
  input logic               CLOCK,
  input logic               RESET_N,
  controle_envase_if.master bus
);
  localparam int unsigned RW    = $clog2(ROLHAS_MAX + 1);
  localparam int unsigned GW    = $clog2(LOTE);
  localparam int unsigned T_MAX = (T_ENCHE_MAX > T_VEDA_MAX) ? T_ENCHE_MAX : T_VEDA_MAX;
  localparam int unsigned TW    = $clog2(T_MAX);

  localparam logic [TW-1:0] ENCHE_ULT = TW'(T_ENCHE_MAX - 1);
  localparam logic [TW-1:0] VEDA_ULT  = TW'(T_VEDA_MAX - 1);
  localparam logic [GW-1:0] LOTE_ULT  = GW'(LOTE - 1);
  localparam logic [RW-1:0] CONT_MAX  = RW'(ROLHAS_MAX);

  typedef enum logic [2:0] {
    S_PARADO, S_ESTEIRA, S_ENCHENDO, S_VEDANDO, S_LIBERANDO, S_ALARME
  } estado_t;

  estado_t       estado_q, estado_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    cod_q, cod_d;
  logic [GW-1:0] garrafas_q, garrafas_d;
  logic          lote_q, lote_d;
  logic [RW-1:0] cont_q, cont_d;
  logic          saida;
  logic          dec_valido;
  logic [31:0]   soma;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      estado_q   <= S_PARADO;
      timer_q    <= '0;
      cod_q      <= 2'b00;
      garrafas_q <= '0;
      lote_q     <= 1'b0;
      cont_q     <= '0;
    end else begin
      estado_q   <= estado_d;
      timer_q    <= timer_d;
      cod_q      <= cod_d;
      garrafas_q <= garrafas_d;
      lote_q     <= lote_d;
      cont_q     <= cont_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    cod_d    = cod_q;
    saida    = 1'b0;
    case (estado_q)
      S_PARADO:
        if (bus.START && (cont_q != '0)) estado_d = S_ESTEIRA;
      S_ESTEIRA:
        if (bus.SENSOR_GARRAFA)  estado_d = S_ENCHENDO;
        else if (!bus.START)     estado_d = S_PARADO;
      S_ENCHENDO:
        if (!bus.SENSOR_GARRAFA) begin
          estado_d = S_ALARME;
          cod_d    = 2'b11;
        end else if (bus.SENSOR_NIVEL) begin
          estado_d = S_VEDANDO;
        end else if (timer_q == ENCHE_ULT) begin
          estado_d = S_ALARME;
          cod_d    = 2'b01;
        end
      S_VEDANDO:
        if (!bus.SENSOR_GARRAFA) begin
          estado_d = S_ALARME;
          cod_d    = 2'b11;
        end else if (bus.GARRAFA_VEDADA) begin
          estado_d = S_LIBERANDO;
        end else if (timer_q == VEDA_ULT) begin
          estado_d = S_ALARME;
          cod_d    = 2'b10;
        end
      // The bottle is finished even if START dropped while it was on the station.
      S_LIBERANDO:
        if (!bus.SENSOR_GARRAFA) begin
          saida    = 1'b1;
          estado_d = (bus.START && (cont_q != '0)) ? S_ESTEIRA : S_PARADO;
        end
      S_ALARME:
        if (bus.ALARME_ACK) begin
          estado_d = S_PARADO;
          cod_d    = 2'b00;
        end
      default: estado_d = S_PARADO;
    endcase
  end

  always_comb begin
    timer_d = '0;
    if ((estado_d == estado_q) &&
        ((estado_q == S_ENCHENDO) || (estado_q == S_VEDANDO)))
      timer_d = timer_q + 1'b1;
  end

  always_comb begin
    garrafas_d = garrafas_q;
    lote_d     = 1'b0;
    if (saida) begin
      if (garrafas_q == LOTE_ULT) begin
        garrafas_d = '0;
        lote_d     = 1'b1;
      end else begin
        garrafas_d = garrafas_q + 1'b1;
      end
    end
  end

  // Cork stock: decrement never underflows, refill saturates at magazine capacity.
  always_comb begin
    dec_valido = bus.DECREMENTA_ROLHA && (cont_q != '0);
    soma       = {{(32-RW){1'b0}}, cont_q} - {31'b0, dec_valido}
               + (bus.ABASTECE_ROLHAS ? REFILL_QTD : 32'd0);
    cont_d     = (soma > ROLHAS_MAX) ? CONT_MAX : soma[RW-1:0];
  end

  assign bus.MOTOR              = (estado_q == S_ESTEIRA) || (estado_q == S_LIBERANDO);
  assign bus.VALVULA            = (estado_q == S_ENCHENDO);
  assign bus.GARRAFA_PRESENTE   = ((estado_q == S_VEDANDO) || (estado_q == S_LIBERANDO))
                                  && bus.SENSOR_GARRAFA;
  assign bus.ROLHAS_DISPONIVEIS = (cont_q != '0);
  assign bus.ROLHAS_CONT        = cont_q;
  assign bus.GARRAFAS_CONT      = garrafas_q;
  assign bus.LOTE_COMPLETO      = lote_q;
  assign bus.ALARME             = (estado_q == S_ALARME);
  assign bus.ALARME_COD         = cod_q;
endmodule
